divide: RTL
===========

// Module: divide
// PURPOSE
//  Sequential radix-2 restoring divider. It is the inverse of the bignum multiply block:
//  a 2*WIDTH-bit dividend (for example a multiply product) divided by a WIDTH-bit divisor
//  gives a 2*WIDTH-bit quotient and a WIDTH-bit remainder. Used in the Paillier datapath
//  for L(x)=(x-1)/n and for modular reduction of products.
//  The start/end handshake is level based and has the same shape as multiply.
// PARAMETERS
//  WIDTH   4096   divisor and remainder width; dividend and quotient are 2*WIDTH bits
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         asynchronous, active-high reset
//  div_begin   in   1         level request; operands are sampled in IDLE when this is 1
//  div_op1     in   2*WIDTH   dividend
//  div_op2     in   WIDTH     divisor
//  quotient    out  2*WIDTH   floor(div_op1/div_op2); valid while div_end=1
//  remainder   out  WIDTH     div_op1 mod div_op2; valid while div_end=1
//  div_end     out  1         result valid; held high until div_begin drops
//  div_zero    out  1         divisor was 0; valid while div_end=1
// BEHAVIOUR
//  - Reset (async, any state, including mid-operation): FSM goes to IDLE.
//    quotient=0, remainder=0, div_end=0, div_zero=0, bit counter=0.
//  - States and transitions:
//    IDLE -> BUSY when div_begin=1 and div_op2!=0.
//    IDLE -> DONE when div_begin=1 and div_op2==0.
//    BUSY -> DONE when the counter reaches 2*WIDTH-1.
//    DONE -> IDLE when div_begin=0.
//  - IDLE with div_begin=1 latches operands into internal registers:
//    dividend shift register Q = div_op1, divisor register D = div_op2,
//    partial remainder R (WIDTH+1 bits) = 0, counter = 0.
//    Later operand changes are ignored until the next IDLE.
//  - BUSY: one quotient bit per cycle, MSB first.
//    T = {R[WIDTH-1:0], Q[2W-1]} - {1'b0, D}.
//    If T >= 0: R = T[WIDTH:0] and shift 1 into Q.
//    Else: R = {R[WIDTH-1:0], Q[2W-1]} and shift 0 into Q.
//    R must be WIDTH+1 bits so the shift never overflows.
//  - Latency: 1 capture cycle + 2*WIDTH BUSY cycles.
//    div_end rises 2*WIDTH+1 clocks after the first clk edge with div_begin=1 in IDLE.
//    Divide by zero: div_end rises 1 clock after capture.
//  - DONE: quotient=Q, remainder=R[WIDTH-1:0], div_end=1.
//    Outputs hold stable while div_begin stays 1; no restart happens.
//    Dropping div_begin gives div_end=0 on the next edge (IDLE). Outputs keep their value.
//  - Divide by zero: quotient = all ones, remainder = div_op1[WIDTH-1:0], div_zero=1.
//  - div_begin falling in BUSY is ignored; the operation completes.
//    It then leaves DONE one cycle later.
//  - Boundaries:
//    op1 < op2: quotient=0, remainder=op1.
//    op2=1: quotient=op1, remainder=0.
//    op1=0: quotient=0, remainder=0.
//    The quotient may use all 2*WIDTH bits.
// STRUCTURE
//  - Shared package: FSM state encodings S_IDLE/S_BUSY/S_DONE (2 bits).
//    Counter width is $clog2(2*WIDTH).
//  - One natural sub-module: div_step, the combinational restore/subtract for one bit.
//    Inputs R, the Q MSB and D; outputs next R and the quotient bit.
//    All registers and the FSM stay in divide.
// TESTING (bench at WIDTH=4096 and at WIDTH=8 for exhaustive corners)
//  1. op1=72000, op2=320 -> quotient=225, remainder=0, div_end after 8193 clocks.
//     This inverts the multiply test 225*320.
//  2. WIDTH=8: op1=16'hFFFF, op2=8'h01 -> quotient=16'hFFFF, remainder=0.
//     Also op1=16'h0007, op2=8'h09 -> quotient=0, remainder=7.
//  3. WIDTH=8: op2=0, op1=16'h1234 -> div_end after 1 clock, div_zero=1,
//     quotient=16'hFFFF, remainder=8'h34.
//  4. WIDTH=8: assert rst mid-BUSY (counter=5) -> outputs 0 and IDLE immediately.
//     Then a new request 1000/7 -> quotient=142, remainder=6.
//  5. Hold div_begin high after div_end -> outputs stable for 20 cycles and no restart.
//     Drop div_begin -> div_end=0 next edge. Re-raise it -> new run.
//  6. WIDTH=8: random 10k vectors checked against a reference model:
//     quotient*op2 + remainder == op1, and remainder < op2.

Source files
------------

// File: rtl/divide_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// the bit-counter width helper.
package divide_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One quotient bit per BUSY cycle, so the counter spans 2*width steps.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/divide_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module div_step #(
  parameter int WIDTH = 4096
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {r_in[WIDTH-1:0], q_msb};
    diff    = {1'b0, shifted} - {2'b00, d};
    // A set top bit in r_in means the shifted value exceeds any divisor.
    q_bit   = r_in[WIDTH] | ~diff[WIDTH+1];
    r_out   = q_bit ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/divide.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, MSB first.
module divide
  import divide_pkg::*;
#(
  parameter int WIDTH = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_begin,
  input  logic [2*WIDTH-1:0]   div_op1,
  input  logic [WIDTH-1:0]     div_op2,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_end,
  output logic                 div_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * WIDTH - 1);

  // Handshake: div_begin is a level request sampled in IDLE; div_end rises when
  // results are valid and stays high until div_begin is seen low in DONE.
  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_end_q, div_end_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     r_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_msb (q_q[2*WIDTH-1]),
    .d     (d_q),
    .r_out (r_next),
    .q_bit (q_bit)
  );

  assign q_next = {q_q[2*WIDTH-2:0], q_bit};

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_end_d   = div_end_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      S_IDLE: begin
        div_end_d = 1'b0;
        if (div_begin) begin
          q_d   = div_op1;
          d_d   = div_op2;
          r_d   = '0;
          cnt_d = '0;
          if (div_op2 == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = div_op1[WIDTH-1:0];
            div_zero_d  = 1'b1;
            div_end_d   = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = S_DONE;
          quotient_d  = q_next;
          remainder_d = r_next[WIDTH-1:0];
          div_zero_d  = 1'b0;
          div_end_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (!div_begin) begin
          state_d   = S_IDLE;
          div_end_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        div_end_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_end_q   <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_end_q   <= div_end_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_end   = div_end_q;
  assign div_zero  = div_zero_q;

endmodule
